alu_mdu_seq: RTL and testbench
==============================

Name: alu_mdu_seq

Overview:
Parametrised, handshaked successor to the single-cycle execute ALU.
- Executes all RV32I ALU operations, with a registered result.
- Adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative shift-add / restoring-divide engine.
- Sits in the execute stage between the decode/register-read and writeback pipeline registers. Uses valid/ready on both sides, so the pipeline stalls while a multi-cycle op runs.

Parameters:
XLEN, 32, datapath width (legal: 32, 64); shift amount width SHW = $clog2(XLEN)
OP_W, 5, operation code width; bit 4 = 1 selects an M-extension op

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block can accept an operation
pc  in  XLEN  instruction address (AUIPC)
rs1_data  in  XLEN  source operand A
rs2_data  in  XLEN  source register B
imm  in  XLEN  sign-extended immediate
operand  in  OP_W  operation code
instr_type  in  3  3'b000 = R-type (B = rs2_data); any other value: B = imm
out_valid  out  1  alu_result valid
out_ready  in  1  consumer accepts result
alu_result  out  XLEN  result
busy  out  1  multi-cycle engine iterating

Behaviour:
Reset values (rst high at clk edge, including mid-operation):
- State = IDLE; out_valid = 0; alu_result = 0; busy = 0; in_ready = 1 on the next cycle.
- Any in-flight op is discarded.

Operand B: rs2_data when instr_type == 3'b000, else imm. Applies to every op except SUB (always rs2_data), LUI and AUIPC.

Base ops (operand[4] = 0), all modulo 2^XLEN:
- 00010 ADD; 00110 SUB; 00001 XOR; 00000 OR; 00011 AND.
- 00100 SLL, 00111 SRL, 01100 SRA: shift amount = B[SHW-1:0].
- 01010 SLT (signed), 01011 SLTU: result is 1 or 0; SLTI/SLTIU compare against imm.
- 00101 LUI = imm; 01000 AUIPC = pc + imm.
- Undefined codes: result = 0.

M ops (operand[4] = 1):
- 10000 MUL = low XLEN bits of the product.
- 10001 MULH (signed×signed), 10010 MULHSU (signed rs1 × unsigned B), 10011 MULHU (unsigned×unsigned): high XLEN bits of the product.
- 10100 DIV, 10101 DIVU: quotient, truncated toward zero.
- 10110 REM, 10111 REMU: remainder; sign follows the dividend.
- Signed ops iterate on magnitudes, then apply sign correction on the final cycle.

FSM: IDLE -> BUSY -> DONE.
- in_ready = (state == IDLE). An op is accepted at edge N when in_valid && in_ready.
- Base op, or M op resolved by a special case: IDLE -> DONE; out_valid = 1 from cycle N+1 (latency 1).
- Other M ops: IDLE -> BUSY, busy = 1. Exactly XLEN iterations, one bit per cycle. BUSY -> DONE with out_valid = 1 at cycle N+XLEN+1.
- DONE: alu_result and out_valid are held stable until out_ready. At the edge where out_valid && out_ready, go to IDLE. A new op is accepted no earlier than the following edge.
- Operands are captured at acceptance; input changes during BUSY/DONE are ignored.

Special cases (1-cycle):
- Divide by zero: DIV/DIVU = all ones; REM/REMU = dividend.
- Signed overflow (most negative / -1): DIV = most negative; REM = 0.
- Multiply by 0: result 0.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (OP_W bits, all codes above).
  - INSTR_R = 3'b000.
  - Default XLEN.
  - state_e {IDLE, BUSY, DONE}.
- Sub-module alu_muldiv_iter holds the iterative engine: accumulator/partial remainder, bit counter, sign-fix logic, start/done pulses.
- The top level holds the combinational base ALU, the FSM and the output register.

Test Plan:
- ADD, instr_type 000, rs1 = 5, rs2 = 7 -> alu_result = 12, out_valid at N+1; ADDI with imm = -1 -> 4.
- SRAI rs1 = 0x80000000, imm = 4 -> 0xF8000000; SLTI rs1 = -3, imm = 2 -> 1; SLTU 1 vs 0xFFFFFFFF -> 1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH -1×-1 -> 0; MUL 7×-3 -> 0xFFFFFFEB. out_valid exactly at N+33 with busy high for 32 cycles.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU x/0 -> 0xFFFFFFFF in 1 cycle; DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Hold out_ready low 5 cycles after DONE -> alu_result and out_valid stable, in_ready = 0, new in_valid ignored; release -> IDLE the next cycle.
- Assert rst at iteration 10 of DIVU -> next cycle out_valid = 0, busy = 0, alu_result = 0, in_ready = 1; the next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU / M-extension execute unit.
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int ALU_OP_W     = 5;
   localparam logic [2:0] INSTR_R = 3'b000;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_OR     = 5'b00000,
      OP_XOR    = 5'b00001,
      OP_ADD    = 5'b00010,
      OP_AND    = 5'b00011,
      OP_SLL    = 5'b00100,
      OP_LUI    = 5'b00101,
      OP_SUB    = 5'b00110,
      OP_SRL    = 5'b00111,
      OP_AUIPC  = 5'b01000,
      OP_SLT    = 5'b01010,
      OP_SLTU   = 5'b01011,
      OP_SRA    = 5'b01100,
      OP_MUL    = 5'b10000,
      OP_MULH   = 5'b10001,
      OP_MULHSU = 5'b10010,
      OP_MULHU  = 5'b10011,
      OP_DIV    = 5'b10100,
      OP_DIVU   = 5'b10101,
      OP_REM    = 5'b10110,
      OP_REMU   = 5'b10111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   // Multiply group is 100xx; divide/remainder group is 101xx.
   function automatic logic is_mul(alu_op_e op);
      return op[4] && !op[2];
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative M-extension engine: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sign correction folded into the last cycle.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

   logic            busy_q;
   logic [SHW-1:0]  cnt_q;
   alu_op_e         op_q;
   logic [XLEN-1:0] acc_q, lo_q, opb_q;
   logic            neg_a_q, neg_b_q;

   logic            a_neg, b_neg;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic            qbit;
   logic [XLEN-1:0] nxt_acc, nxt_lo;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0] quo_fix, rem_fix;

   assign a_neg = (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM) && a[XLEN-1];
   assign b_neg = (op == OP_MULH || op == OP_DIV || op == OP_REM) && b[XLEN-1];

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == LAST);

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
      end else if (busy_q) begin
         cnt_q <= cnt_q + 1'b1;
         if (done) busy_q <= 1'b0;
      end
   end

   // NOTE: datapath registers carry no reset; they are always loaded by start before use.
   always_ff @(posedge clk) begin
      if (start) begin
         op_q    <= op;
         neg_a_q <= a_neg;
         neg_b_q <= b_neg;
         acc_q   <= '0;
         lo_q    <= a_neg ? -a : a;
         opb_q   <= b_neg ? -b : b;
      end else if (busy_q) begin
         acc_q <= nxt_acc;
         lo_q  <= nxt_lo;
      end
   end

   // Multiply: acc holds the running high half, lo shifts the multiplier out.
   // Divide: acc is the partial remainder, lo shifts the dividend out and quotient in.
   assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
   assign div_shift = {acc_q, lo_q[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign qbit      = ~div_diff[XLEN];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      nxt_acc = mul_sum[XLEN:1];
      nxt_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
      if (op_q[2]) begin
         nxt_acc = qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
         nxt_lo  = {lo_q[XLEN-2:0], qbit};
      end
   end

   assign prod     = {nxt_acc, nxt_lo};
   assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
   assign quo_fix  = (neg_a_q ^ neg_b_q) ? -nxt_lo : nxt_lo;
   assign rem_fix  = neg_a_q ? -nxt_acc : nxt_acc;

   always_comb begin
      result = rem_fix;
      case (op_q)
         OP_MUL:                       result = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              result = quo_fix;
         default:                      result = rem_fix;
      endcase
   end

endmodule

// File: rtl/alu_mdu_seq.sv
// Handshaked execute unit: single-cycle RV32I ALU plus an iterative M-extension
// engine behind an IDLE/BUSY/DONE controller with a registered result.
module alu_mdu_seq
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int OP_W = ALU_OP_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic [OP_W-1:0] operand,
   input  logic [2:0]      instr_type,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_result,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   alu_op_e         op;
   logic [XLEN-1:0] b, base_res, special_res, result_q, eng_result;
   logic            accept, special, eng_start, eng_busy, eng_done;

   assign op        = alu_op_e'(operand);
   assign b         = (instr_type == INSTR_R) ? rs2_data : imm;
   assign accept    = in_valid && (state_q == IDLE);
   assign eng_start = accept && operand[4] && !special;

   always_comb begin
      base_res = '0;
      case (op)
         OP_ADD:   base_res = rs1_data + b;
         OP_SUB:   base_res = rs1_data - rs2_data;
         OP_XOR:   base_res = rs1_data ^ b;
         OP_OR:    base_res = rs1_data | b;
         OP_AND:   base_res = rs1_data & b;
         OP_SLL:   base_res = rs1_data << b[SHW-1:0];
         OP_SRL:   base_res = rs1_data >> b[SHW-1:0];
         OP_SRA:   base_res = $unsigned($signed(rs1_data) >>> b[SHW-1:0]);
         OP_SLT:   base_res = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(b)};
         OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, rs1_data < b};
         OP_LUI:   base_res = imm;
         OP_AUIPC: base_res = pc + imm;
         default:  base_res = '0;
      endcase
   end

   // M ops whose answer is known without iterating finish in one cycle.
   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (is_mul(op)) begin
         special = (rs1_data == '0) || (b == '0);
      end else if (b == '0) begin
         special     = 1'b1;
         special_res = (op == OP_REM || op == OP_REMU) ? rs1_data : '1;
      end else if ((op == OP_DIV || op == OP_REM) && rs1_data == MIN_NEG && b == '1) begin
         special     = 1'b1;
         special_res = (op == OP_DIV) ? MIN_NEG : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = eng_start ? BUSY : DONE;
         BUSY:    if (eng_done) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                      result_q <= '0;
      else if (accept && !eng_start) result_q <= operand[4] ? special_res : base_res;
      else if (eng_done)            result_q <= eng_result;
   end

   alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (eng_start),
      .op     (op),
      .a      (rs1_data),
      .b      (b),
      .busy   (eng_busy),
      .done   (eng_done),
      .result (eng_result)
   );

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign alu_result = result_q;
   assign busy       = eng_busy;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: a driver queues reference results, a monitor
// compares them (plus latency and busy cycles) whenever the DUT presents a result.
module tb_alu_mdu_seq;

   localparam int XLEN = 32;

   localparam logic [4:0] T_OR = 5'b00000, T_XOR = 5'b00001, T_ADD = 5'b00010, T_AND = 5'b00011;
   localparam logic [4:0] T_SLL = 5'b00100, T_LUI = 5'b00101, T_SUB = 5'b00110, T_SRL = 5'b00111;
   localparam logic [4:0] T_AUIPC = 5'b01000, T_SLT = 5'b01010, T_SLTU = 5'b01011, T_SRA = 5'b01100;
   localparam logic [4:0] T_MUL = 5'b10000, T_MULH = 5'b10001, T_MULHSU = 5'b10010, T_MULHU = 5'b10011;
   localparam logic [4:0] T_DIV = 5'b10100, T_DIVU = 5'b10101, T_REM = 5'b10110, T_REMU = 5'b10111;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, busy;
   logic [31:0] pc = '0, rs1_data = '0, rs2_data = '0, imm = '0, alu_result;
   logic [4:0]  operand = '0;
   logic [2:0]  instr_type = '0;

   int total = 0, bad = 0, cyc = 0, ready_mode = 2;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          busy_cyc;
      int          acc_edge;
      string       name;
   } exp_t;
   exp_t sb[$];

   alu_mdu_seq #(.XLEN(XLEN), .OP_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .operand(operand),
      .instr_type(instr_type), .out_valid(out_valid), .out_ready(out_ready),
      .alu_result(alu_result), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = ($urandom % 4) != 0;
         1:       out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain arithmetic on the architectural rules.
   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, r2, im, p,
                                         input logic [2:0] it, output int lat);
      logic [31:0] bv, r;
      logic signed [63:0] sa, sbv, sp;
      logic [63:0] up;
      logic signed [31:0] q;
      bv  = (it == 3'b000) ? r2 : im;
      sa  = $signed(a);
      sbv = $signed(bv);
      lat = 1;
      r   = '0;
      case (op)
         T_ADD:   r = a + bv;
         T_SUB:   r = a - r2;
         T_XOR:   r = a ^ bv;
         T_OR:    r = a | bv;
         T_AND:   r = a & bv;
         T_SLL:   r = a << bv[4:0];
         T_SRL:   r = a >> bv[4:0];
         T_SRA:   r = $signed(a) >>> bv[4:0];
         T_SLT:   r = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
         T_SLTU:  r = (a < bv) ? 32'd1 : 32'd0;
         T_LUI:   r = im;
         T_AUIPC: r = p + im;
         T_MUL, T_MULH, T_MULHSU, T_MULHU: begin
            lat = (a == 0 || bv == 0) ? 1 : XLEN + 1;
            case (op)
               T_MUL:    begin sp = sa * sbv; r = sp[31:0]; end
               T_MULH:   begin sp = sa * sbv; r = sp[63:32]; end
               T_MULHSU: begin sp = sa * $signed({32'b0, bv}); r = sp[63:32]; end
               default:  begin up = {32'b0, a} * {32'b0, bv}; r = up[63:32]; end
            endcase
         end
         T_DIV, T_REM: begin
            if (bv == 0) begin
               r = (op == T_DIV) ? 32'hFFFF_FFFF : a;
            end else if (a == MINV && bv == 32'hFFFF_FFFF) begin
               r = (op == T_DIV) ? MINV : 32'd0;
            end else begin
               q   = (op == T_DIV) ? $signed(a) / $signed(bv) : $signed(a) % $signed(bv);
               r   = q;
               lat = XLEN + 1;
            end
         end
         T_DIVU, T_REMU: begin
            if (bv == 0) begin
               r = (op == T_DIVU) ? 32'hFFFF_FFFF : a;
            end else begin
               r   = (op == T_DIVU) ? a / bv : a % bv;
               lat = XLEN + 1;
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a, r2, im, p,
                        input logic [2:0] it);
      exp_t e;
      int   lat, guard;
      e.res = model(op, a, r2, im, p, it, lat);
      @(negedge clk);
      rs1_data = a; rs2_data = r2; imm = im; pc = p; operand = op; instr_type = it;
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check({name, "_accept_timeout"}, {31'b0, in_ready}, 32'd1);
         in_valid = 1'b0;
         return;
      end
      e.lat      = lat;
      e.busy_cyc = (lat == XLEN + 1) ? XLEN : 0;
      e.acc_edge = cyc + 1;
      e.name     = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; pc = $urandom;
      operand = 5'($urandom); instr_type = 3'($urandom);
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom % 8)
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return MINV;
         3:       return $urandom % 16;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: compare the queue head whenever a result is presented.
   int seen = 0, first_cyc = 0, busy_cnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         seen     = 0;
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", {31'b0, out_valid}, 32'd0);
            end else begin
               if (seen == 0) begin
                  seen      = 1;
                  first_cyc = cyc;
               end
               check({sb[0].name, "_result"}, alu_result, sb[0].res);
               if (out_ready) begin
                  check({sb[0].name, "_latency"}, first_cyc + 1 - sb[0].acc_edge, sb[0].lat);
                  check({sb[0].name, "_busy_cycles"}, busy_cnt, sb[0].busy_cyc);
                  void'(sb.pop_front());
                  seen     = 0;
                  busy_cnt = 0;
               end
            end
         end
      end
   end

   logic [4:0] op_list [24] = '{T_ADD, T_SUB, T_XOR, T_OR, T_AND, T_SLL, T_SRL, T_SRA,
                                T_SLT, T_SLTU, T_LUI, T_AUIPC, T_MUL, T_MULH, T_MULHSU, T_MULHU,
                                T_DIV, T_DIVU, T_REM, T_REMU, 5'b01001, 5'b01101, 5'b01110, 5'b01111};

   initial begin
      int cnt, guard;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", {31'b0, in_ready}, 32'd1);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_result", alu_result, 32'd0);

      issue("add", T_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 3'b000);
      issue("addi", T_ADD, 32'd5, 32'd7, 32'hFFFF_FFFF, 32'd0, 3'b001);
      issue("srai", T_SRA, MINV, 32'd0, 32'd4, 32'd0, 3'b001);
      issue("slti", T_SLT, 32'hFFFF_FFFD, 32'd0, 32'd2, 32'd0, 3'b001);
      issue("sltu", T_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 3'b000);
      issue("sub_itype", T_SUB, 32'd10, 32'd3, 32'd99, 32'd0, 3'b001);
      issue("lui", T_LUI, 32'd1, 32'd2, 32'h1234_5000, 32'd0, 3'b010);
      issue("auipc", T_AUIPC, 32'd1, 32'd2, 32'h20, 32'h1000, 3'b010);
      issue("undef", 5'b01001, 32'd3, 32'd4, 32'd5, 32'd0, 3'b000);
      issue("mulhu", T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 3'b000);
      issue("mulh", T_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 3'b000);
      issue("mul", T_MUL, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, 3'b000);
      issue("mul_zero", T_MUL, 32'd0, 32'd9, 32'd0, 32'd0, 3'b000);
      issue("div", T_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 3'b000);
      issue("rem", T_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 3'b000);
      issue("divu_zero", T_DIVU, 32'd1234, 32'd0, 32'd0, 32'd0, 3'b000);
      issue("remu_zero", T_REMU, 32'd1234, 32'd0, 32'd0, 32'd0, 3'b000);
      issue("div_ovf", T_DIV, MINV, 32'hFFFF_FFFF, 32'd0, 32'd0, 3'b000);
      issue("rem_ovf", T_REM, MINV, 32'hFFFF_FFFF, 32'd0, 32'd0, 3'b000);
      drain();

      // Back-pressure: result must hold and new offers must be ignored.
      ready_mode = 1;
      issue("hold_mul", T_MUL, 32'd123, 32'd456, 32'd0, 32'd0, 3'b000);
      guard = 0;
      while (!out_valid && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      for (int i = 0; i < 5; i++) begin
         check("hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("hold_out_valid", {31'b0, out_valid}, 32'd1);
         operand  = T_ADD;
         rs1_data = $urandom;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid   = 1'b0;
      ready_mode = 2;
      repeat (2) @(negedge clk);
      check("release_in_ready", {31'b0, in_ready}, 32'd1);
      check("release_out_valid", {31'b0, out_valid}, 32'd0);
      drain();

      // Reset in the middle of a divide.
      issue("divu_rst", T_DIVU, 32'hDEAD_BEEF, 32'd7, 32'd0, 32'd0, 3'b000);
      cnt   = 0;
      guard = 0;
      while (cnt < 10 && guard < 100) begin
         @(negedge clk);
         if (busy) cnt++;
         guard++;
      end
      @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_result", alu_result, 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      issue("add_after_rst", T_ADD, 32'd20, 32'd22, 32'd0, 32'd0, 3'b000);
      drain();

      ready_mode = 0;
      for (int i = 0; i < 120; i++) begin
         logic [2:0] it;
         it = ($urandom % 2 == 0) ? 3'b000 : 3'($urandom_range(1, 7));
         issue("rand", op_list[$urandom_range(0, 23)], rand_val(), rand_val(), rand_val(),
               $urandom, it);
      end
      ready_mode = 2;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
